// File: rtl/vx_mem_stream_pkg.sv
// Shared types and default widths for the VX memory stream master.
package vx_mem_stream_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_TAG_W  = 8;

   localparam int MEM_LEN_W     = 16;
   localparam int MEM_RSP_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic                  rw;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_TAG_W-1:0]  tag;
      logic [MEM_DATA_W-1:0] data;
   } mem_req_t;

   typedef struct packed {
      logic [MEM_DATA_W-1:0] data;
      logic [MEM_TAG_W-1:0]  tag;
   } mem_rsp_t;

endpackage

// File: rtl/vx_mem_stream_fifo.sv
// Synchronous first-word-fall-through FIFO holding read responses.
// DEPTH must be a power of two so the pointers wrap naturally.
module vx_mem_stream_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          head,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/vx_mem_stream_master.sv
// Turns one host command into single-beat VX memory requests; writes stream
// in from wr_*, read responses stream out on rd_* through a credit-limited FIFO.
// Handshake rule for every port pair: a beat transfers on the rising edge where
// valid and ready are both high; a raised valid keeps its payload stable until then.
module vx_mem_stream_master
   import vx_mem_stream_pkg::*;
#(
   parameter int ADDR_W    = MEM_ADDR_W,
   parameter int DATA_W    = MEM_DATA_W,
   parameter int TAG_W     = MEM_TAG_W,
   parameter int LEN_W     = MEM_LEN_W,
   parameter int RSP_DEPTH = MEM_RSP_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_rw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [TAG_W-1:0]  mem_req_tag,
   output logic [DATA_W-1:0] mem_req_data,
   input  logic              mem_rsp_valid,
   output logic              mem_rsp_ready,
   input  logic [DATA_W-1:0] mem_rsp_data,
   input  logic [TAG_W-1:0]  mem_rsp_tag,
   output logic              busy,
   output logic              done,
   output logic              err,
   output state_t            state_dbg
);
   localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

   state_t            state;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issue_cnt;
   logic [LEN_W-1:0]  rd_cnt;
   logic [TAG_W-1:0]  tag_q;
   logic [TAG_W-1:0]  retire_tag;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    credit_used;
   logic              fifo_empty;
   logic              fifo_full;
   logic              cmd_fire;
   logic              req_fire;
   logic              rsp_fire;
   logic              rd_fire;
   logic              read_active;
   logic              rsp_expected;
   logic              fifo_push;
   logic              last_req;
   logic              last_rd;
   mem_req_t          req;
   mem_rsp_t          rsp;

   assign cmd_ready     = (state == IDLE);
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);
   assign state_dbg     = state;
   assign cmd_fire      = cmd_valid && cmd_ready;
   assign req_fire      = mem_req_valid && mem_req_ready;
   assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
   assign rd_fire       = rd_valid && rd_ready;
   assign read_active   = ((state == ISSUE) || (state == DRAIN)) && !rw_q;
   assign rsp_expected  = read_active && (outstanding != '0);
   assign fifo_push     = rsp_fire && rsp_expected;
   assign last_req      = (issue_cnt == len_q - LEN_W'(1));
   assign last_rd       = rd_fire && (rd_cnt == len_q - LEN_W'(1));
   assign credit_used   = {1'b0, outstanding} + {1'b0, fifo_count};
   assign mem_rsp_ready = !fifo_full;
   assign rd_valid      = !fifo_empty;
   assign rsp           = '{data: mem_rsp_data, tag: mem_rsp_tag};

   // Request channel: write data passes straight through; reads are credit gated
   // so every issued read already owns a FIFO slot.
   always_comb begin
      req           = '0;
      mem_req_valid = 1'b0;
      wr_ready      = 1'b0;
      req.rw        = rw_q;
      req.addr      = addr_q;
      req.tag       = tag_q;
      req.data      = rw_q ? wr_data : '0;
      if (state == ISSUE) begin
         if (rw_q) begin
            mem_req_valid = wr_valid;
            wr_ready      = mem_req_ready;
         end else begin
            mem_req_valid = (credit_used < (CNT_W + 1)'(RSP_DEPTH));
         end
      end
   end

   assign mem_req_rw   = req.rw;
   assign mem_req_addr = req.addr;
   assign mem_req_tag  = req.tag;
   assign mem_req_data = req.data;

   // Command sequencer: latch the command, walk address/tag, track completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         tag_q     <= '0;
         issue_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_fire) begin
                  rw_q      <= cmd_rw;
                  addr_q    <= cmd_addr;
                  len_q     <= cmd_len;
                  tag_q     <= '0;
                  issue_cnt <= '0;
                  state     <= (cmd_len == '0) ? DONE : ISSUE;
               end
            end
            ISSUE: begin
               if (req_fire) begin
                  addr_q    <= addr_q + ADDR_W'(1);
                  tag_q     <= tag_q + TAG_W'(1);
                  issue_cnt <= issue_cnt + LEN_W'(1);
                  if (last_req) state <= rw_q ? DONE : DRAIN;
               end
            end
            DRAIN: begin
               if (last_rd) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Response side: outstanding credits, in-order tag check, delivered beats, sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding <= '0;
         retire_tag  <= '0;
         rd_cnt      <= '0;
         err         <= 1'b0;
      end else if (cmd_fire) begin
         outstanding <= '0;
         retire_tag  <= '0;
         rd_cnt      <= '0;
         // A stray response in the same cycle is still an error for the new command.
         err         <= rsp_fire;
      end else begin
         outstanding <= outstanding + CNT_W'(req_fire && !rw_q) - CNT_W'(fifo_push);
         if (fifo_push) retire_tag <= retire_tag + TAG_W'(1);
         if (rd_fire && read_active) rd_cnt <= rd_cnt + LEN_W'(1);
         if ((fifo_push && (rsp.tag != retire_tag)) || (rsp_fire && !rsp_expected))
            err <= 1'b1;
      end
   end

   vx_mem_stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (rsp.data),
      .pop       (rd_fire),
      .head      (rd_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

endmodule
